fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side adapter for the team's put/get FIFOs, including the cascaded depth-expanded FIFO. It drains a FIFO through its `get`/`empty`/`data_out` port and presents the words as a valid/ready stream. A 2-entry internal buffer absorbs the FIFO's one-cycle read latency, so a downstream consumer that is always ready receives one word per cycle. It sits between any FIFO instance and its consuming logic.

## Interface
- `WIDTH`, 16, data word width; must match the attached FIFO.
- `BUF_DEPTH`, 2, internal buffer entries; fixed at 2, and the parameter exists for package consistency only.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `fifo_data_out` input WIDTH: the FIFO's read data, valid one cycle after an accepted get.
- `fifo_empty` input 1: the FIFO's empty flag.
- `fifo_get` output 1: read strobe to the FIFO's `get`.
- `flush` input 1: discards all buffered and in-flight words.
- `m_data` output WIDTH: stream data.
- `m_valid` output 1: `m_data` holds a word.
- `m_ready` input 1: consumer accepts the word.
- `buf_count` output 2: words currently held in the buffer (0–2).
- `word_count` output 16: present only with `FIFO_READER_STATS_EN`.

## Operation
- Upstream contract:
  - The FIFO returns the head word on `fifo_data_out` in the cycle after `fifo_get` is sampled high while `fifo_empty` is low.
  - `fifo_get` must never be asserted while `fifo_empty` is high. This is combinationally guaranteed.
- Tracked state:
  - `occ` (0..2): buffered words.
  - `inflight` (0/1): a get was issued last cycle and its data arrives this cycle.
- Issue rule: `fifo_get = !reset && !flush && !fifo_empty && (occ + inflight - pop) < 2`, where `pop = m_valid && m_ready`.
- Capture: when `inflight` is 1, `fifo_data_out` is written into the buffer tail that cycle, unless `flush` is high.
- Buffer order is strict FIFO:
  - `m_data` is always the oldest entry.
  - `m_valid = (occ != 0)`.
  - `m_data` is held stable while `m_valid && !m_ready`.
- Occupancy update: `occ_next = occ + capture - pop`.
  - A simultaneous capture and pop at `occ = 2` cannot occur, because the issue rule prevents it.
  - Capture at `occ = 2` without a pop is a design error; the bench asserts it never happens.
- Flush:
  - `occ` is cleared to 0.
  - Any in-flight word arriving in the same cycle is dropped.
  - `fifo_get` is held low during the flush cycle.
  - The `m_ready` pop in the flush cycle is ignored: a word presented in the flush cycle is not counted as delivered.
- `buf_count` equals `occ`.

## Timing
- Reset values: `fifo_get` 0, `m_valid` 0, `m_data` 0, `buf_count` 0, `inflight` 0, `word_count` 0.
- Latency: a word becomes visible on `m_valid` 2 cycles after `fifo_empty` falls:
  - cycle N: get issued;
  - cycle N+1: capture;
  - cycle N+2: `m_valid` is 1.
- Throughput: 1 word/cycle sustained with `m_ready` held high and the FIFO non-empty.
- Backpressure: with `m_ready` low, at most 2 gets are issued; `fifo_get` then stays 0 until a pop.
- Reset in mid-operation:
  - In-flight data in the cycle after reset is ignored, because `inflight` is cleared.
  - The FIFO is reset by the same `reset`, so no words are lost beyond those the FIFO itself clears.

## Configuration
- `FIFO_READER_STATS_EN` defined:
  - `word_count` port exists.
  - It increments by 1 on each pop and wraps from 0xFFFF to 0.
  - It is cleared by `reset` but not by `flush`.
- Not defined: the port and counter are absent, and no other behaviour changes.

## Structure
- Shared package `fifo_pkg` holds:
  - the default `WIDTH` (16);
  - the FIFO read latency constant `FIFO_RD_LAT = 1`;
  - the `BUF_DEPTH = 2` constant.
- One sub-module, `fifo_reader_buf`: the 2-entry register buffer with push, pop and clear inputs and `occ` output.
- Issue and in-flight logic live in the top level.

## Test plan
- Reset then idle: FIFO empty, `m_ready` = 1 → `fifo_get`, `m_valid` and `buf_count` all stay 0 for 10 cycles.
- Streaming: FIFO preloaded with 0x0001..0x0010, `m_ready` = 1 → first `m_valid` 2 cycles after reset release, then 16 consecutive words 0x0001..0x0010 in order, then `m_valid` drops.
- Backpressure: 8 words loaded, `m_ready` = 0 for 6 cycles:
  - exactly 2 gets are issued;
  - `buf_count` = 2;
  - `m_data` is held at 0x0001;
  - after `m_ready` rises, words 0x0001..0x0008 arrive with no loss or duplication.
- Empty boundary: the FIFO holds 1 word and `put`s arrive one every 3 cycles → `fifo_get` is never high while `fifo_empty` = 1, and each word is delivered exactly once.
- Flush with a word in flight: `flush` asserted the cycle after a get, with `buf_count` = 1:
  - next cycle `buf_count` = 0 and `m_valid` = 0;
  - the next delivered word is the FIFO's subsequent head.
- Stats (with the macro defined): 70000 pops → `word_count` = 70000 mod 65536 = 4464; a flush leaves it unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the FIFO read-side adapter
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int FIFO_RD_LAT   = 1;
  localparam int BUF_DEPTH     = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port plus valid/ready output stream
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_empty;
  logic             fifo_get;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  fifo_data_out, fifo_empty, m_ready,
    output fifo_get, m_data, m_valid
  );

  modport slave (
    output fifo_data_out, fifo_empty, m_ready,
    input  fifo_get, m_data, m_valid
  );

endinterface

// File: rtl/fifo_reader_buf.sv
// rtl/fifo_reader_buf.sv - 2-entry in-order register buffer, entry 0 is the oldest
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output occ_t             occ
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  occ_t             occ_q;
  occ_t             occ_d;

  assign head_data = mem_q[0];
  assign occ       = occ_q;

  // Shift on pop so the head always sits in entry 0; push lands behind the last valid entry.
  always_comb begin
    mem_d = mem_q;
    occ_d = occ_q;
    if (clear) begin
      occ_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          mem_d[occ_q[0]] = push_data;
          occ_d           = occ_q + 2'd1;
        end
        2'b01: begin
          mem_d[0] = mem_q[1];
          occ_d    = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            mem_d[0] = push_data;
          end else begin
            mem_d[0] = mem_q[1];
            mem_d[1] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - drains a get/empty FIFO into a valid/ready stream; FIFO_READER_STATS_EN adds word_count
module fifo_reader #(
  parameter int WIDTH     = fifo_pkg::DEFAULT_WIDTH,
  parameter int BUF_DEPTH = fifo_pkg::BUF_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  fifo_reader_if.master  bus,
  output fifo_pkg::occ_t buf_count
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]    word_count
`endif
);

  logic [fifo_pkg::FIFO_RD_LAT-1:0] inflight_q;
  logic [fifo_pkg::FIFO_RD_LAT-1:0] inflight_d;
  fifo_pkg::occ_t                   occ;
  logic [WIDTH-1:0]                 head_data;
  logic                             m_valid;
  logic                             pop_raw;
  logic                             pop_buf;
  logic                             capture;
  logic                             get;
  logic [2:0]                       level;

  assign m_valid     = (occ != 2'd0);
  assign bus.m_valid = m_valid;
  assign bus.m_data  = head_data;
  assign bus.fifo_get = get;
  assign buf_count   = occ;

  // Issue a get only if the word it returns is guaranteed a free slot next cycle.
  always_comb begin
    pop_raw    = m_valid && bus.m_ready;
    pop_buf    = pop_raw && !flush;
    capture    = inflight_q[0] && !flush;
    level      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_raw};
    get        = !reset && !flush && !bus.fifo_empty && (level < 3'(BUF_DEPTH));
    inflight_d = get;
  end

  // A get issued this cycle means its data is on fifo_data_out next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_reader_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (bus.fifo_data_out),
    .pop       (pop_buf),
    .clear     (flush),
    .head_data (head_data),
    .occ       (occ)
  );

`ifdef FIFO_READER_STATS_EN
  logic [15:0] word_count_q;
  logic [15:0] word_count_d;

  assign word_count = word_count_q;

  // Count delivered words; flush-cycle pops are not deliveries, and flush leaves the count alone.
  always_comb begin
    word_count_d = word_count_q + {15'd0, pop_buf};
  end

  // Delivered-word counter register, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader with a behavioural put/get FIFO
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  buf_count;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] word_count;
`endif

  fifo_reader_if #(.WIDTH(16)) bus ();

  fifo_reader #(
    .WIDTH     (16),
    .BUF_DEPTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .buf_count (buf_count)
`ifdef FIFO_READER_STATS_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          gets_cnt = 0;
  logic [15:0] fifo_q [$];
  logic [15:0] exp_q [$];
  logic        s_get;
  logic        s_empty;
  logic        s_reset;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put_word(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    bus.m_ready = ready;
    repeat (2) @(negedge clk);
    exp_q.delete();
    gets_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d words undelivered, required 0", name, exp_q.size());
    end
  endtask

  // FIFO model: data appears one cycle after a sampled get; reset clears it.
  always @(posedge clk) begin
    s_get   = bus.fifo_get;
    s_empty = bus.fifo_empty;
    s_reset = reset;
    #1;
    if (s_reset) begin
      fifo_q.delete();
      bus.fifo_empty    = 1'b1;
      bus.fifo_data_out = '0;
    end else if (s_get) begin
      gets_cnt++;
      checks++;
      if (s_empty || fifo_q.size() == 0) begin
        errors++;
        $display("FAIL get_while_empty: fifo_get 1 with fifo_empty %0b, required no get", s_empty);
      end else begin
        bus.fifo_data_out = fifo_q.pop_front();
      end
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: just before each edge, score every word the consumer accepts.
  always @(negedge clk) begin
    #3;
    if (!reset && !flush) begin
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, required no word", bus.m_data);
        end else if (bus.m_data !== exp_q[0]) begin
          errors++;
          $display("FAIL word_order: got 0x%0h expected 0x%0h", bus.m_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (dut.inflight_q[0] && buf_count == 2'd2 && !(bus.m_valid && bus.m_ready)) begin
        errors++;
        $display("FAIL capture_overflow: capture with buf_count 2 and no pop, required never");
      end
    end
  end

  initial begin
    reset             = 1'b1;
    flush             = 1'b0;
    bus.m_ready       = 1'b1;
    bus.fifo_empty    = 1'b1;
    bus.fifo_data_out = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_fifo_get", {31'd0, bus.fifo_get}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, bus.m_data}, 32'd0);
    chk("rst_buf_count", {30'd0, buf_count}, 32'd0);
`ifdef FIFO_READER_STATS_EN
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
`endif

    // Idle with empty FIFO
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_fifo_get", {31'd0, bus.fifo_get}, 32'd0);
      chk("idle_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("idle_buf_count", {30'd0, buf_count}, 32'd0);
    end

    // Streaming 16 preloaded words
    do_reset(1'b1);
    for (int i = 1; i <= 16; i++) put_word(16'(i));
    @(negedge clk);
    chk("stream_valid_n1", {31'd0, bus.m_valid}, 32'd0);
    @(negedge clk);
    chk("stream_valid_n2", {31'd0, bus.m_valid}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("stream_valid_run", {31'd0, bus.m_valid}, 32'd1);
    end
    @(negedge clk);
    chk("stream_valid_end", {31'd0, bus.m_valid}, 32'd0);
    chk("stream_left", exp_q.size(), 32'd0);

    // Backpressure
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) put_word(16'(i));
    repeat (6) @(negedge clk);
    chk("bp_gets", gets_cnt, 32'd2);
    chk("bp_buf_count", {30'd0, buf_count}, 32'd2);
    chk("bp_m_data", {16'd0, bus.m_data}, 32'h0001);
    chk("bp_fifo_get", {31'd0, bus.fifo_get}, 32'd0);
    bus.m_ready = 1'b1;
    wait_drain(50, "bp_drain");
    chk("bp_gets_total", gets_cnt, 32'd8);

    // Empty boundary: trickle of puts
    do_reset(1'b1);
    put_word(16'h0100);
    for (int k = 1; k <= 6; k++) begin
      repeat (3) @(negedge clk);
      put_word(16'h0100 + 16'(k));
    end
    wait_drain(20, "trickle_drain");
    chk("trickle_gets", gets_cnt, 32'd7);

    // Flush with a word in flight
    do_reset(1'b0);
    put_word(16'h00A1);
    put_word(16'h00A2);
    put_word(16'h00A3);
    repeat (2) @(negedge clk);
    chk("fl_buf_count_pre", {30'd0, buf_count}, 32'd1);
    chk("fl_gets_pre", gets_cnt, 32'd2);
    flush = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge clk);
    flush = 1'b0;
    chk("fl_buf_count", {30'd0, buf_count}, 32'd0);
    chk("fl_m_valid", {31'd0, bus.m_valid}, 32'd0);
    bus.m_ready = 1'b1;
    wait_drain(20, "fl_drain");
    chk("fl_gets_total", gets_cnt, 32'd3);

`ifdef FIFO_READER_STATS_EN
    // Word counter wrap and flush immunity
    do_reset(1'b1);
    for (int i = 0; i < 70000; i++) put_word(16'(i));
    wait_drain(70100, "stats_drain");
    chk("stats_count", {16'd0, word_count}, 32'd4464);
    bus.m_ready = 1'b0;
    put_word(16'hBEEF);
    repeat (3) @(negedge clk);
    chk("stats_valid", {31'd0, bus.m_valid}, 32'd1);
    bus.m_ready = 1'b1;
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    chk("stats_flush_count", {16'd0, word_count}, 32'd4464);
    chk("stats_flush_valid", {31'd0, bus.m_valid}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("final_left", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
